// File: rtl/sc_mem_lsu.sv
// Load/store unit between a valid/ready request port and a single-port word memory.
// Optional macro LSU_MISALIGN_CHECK_EN turns misaligned half/word accesses into errors.
module sc_mem_lsu #(
    parameter int MEM_WORDS = 32
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_sext,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_datain,
    output logic        mem_we,
    input  logic [31:0] mem_dataout
);
    typedef enum logic [2:0] {IDLE, LOAD, READ, WRITE, RESP} state_t;

    localparam logic [29:0] MEM_WORDS_W = 30'(MEM_WORDS);

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        sext_q, sext_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] merged_q, merged_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        misalign;
    logic        req_bad;
    logic        mem_we_raw;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;
    logic [31:0] st_merge;

`ifdef LSU_MISALIGN_CHECK_EN
    assign misalign = ((req_size == 2'b01) && req_addr[0]) ||
                      ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign req_bad = (req_size == 2'b11) || (req_addr[31:2] >= MEM_WORDS_W) || misalign;

    // Lane extraction for loads and lane insertion for read-modify-write stores.
    always_comb begin
        ld_byte = mem_dataout[{addr_q[1:0], 3'b000} +: 8];
        ld_half = addr_q[1] ? mem_dataout[31:16] : mem_dataout[15:0];
        case (size_q)
            2'b00:   ld_val = {{24{sext_q & ld_byte[7]}}, ld_byte};
            2'b01:   ld_val = {{16{sext_q & ld_half[15]}}, ld_half};
            default: ld_val = mem_dataout;
        endcase
        st_merge = mem_dataout;
        if (size_q == 2'b00) begin
            st_merge[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else if (addr_q[1]) begin
            st_merge[31:16] = wdata_q[15:0];
        end else begin
            st_merge[15:0] = wdata_q[15:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        size_d     = size_q;
        sext_d     = sext_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        merged_d   = merged_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        mem_addr   = 32'd0;
        mem_datain = 32'd0;
        mem_we_raw = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    we_d     = req_we;
                    size_d   = req_size;
                    sext_d   = req_sext;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    merged_d = req_wdata;
                    rdata_d  = 32'd0;
                    err_d    = 1'b0;
                    if (req_bad) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else if (!req_we) begin
                        state_d = LOAD;
                    end else if (req_size == 2'b10) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            LOAD: begin
                mem_addr = {addr_q[31:2], 2'b00};
                rdata_d  = ld_val;
                state_d  = RESP;
            end
            READ: begin
                mem_addr = {addr_q[31:2], 2'b00};
                merged_d = st_merge;
                state_d  = WRITE;
            end
            WRITE: begin
                mem_addr   = {addr_q[31:2], 2'b00};
                mem_datain = merged_q;
                mem_we_raw = 1'b1;
                state_d    = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset must also suppress the write strobe on the very edge it is asserted.
    assign mem_we    = mem_we_raw & clrn;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            sext_q   <= 1'b0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            merged_q <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            size_q   <= size_d;
            sext_q   <= sext_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            merged_q <= merged_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end
endmodule

// File: tb/tb_sc_mem_lsu.sv
// Scoreboard bench for sc_mem_lsu: driver queues expected responses, monitor checks them.
module tb_sc_mem_lsu;
    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_sext = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_datain;
    logic        mem_we;
    logic [31:0] mem_dataout;

    sc_mem_lsu #(.MEM_WORDS(32)) dut (
        .clk(clk), .clrn(clrn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_sext(req_sext), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_datain(mem_datain), .mem_we(mem_we),
        .mem_dataout(mem_dataout)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:31];
    assign mem_dataout = mem[mem_addr[6:2]];

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'd0;
        mem[20] = 32'h0000_00a3;
        mem[21] = 32'h0000_0027;
        mem[22] = 32'h1122_3344;
        forever begin
            @(posedge clk);
            if (mem_we) mem[mem_addr[6:2]] = mem_datain;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Memory-side activity tracker
    int we_cnt = 0;
    int we_cyc = -1;
    int acc_cnt = 0;
    always @(negedge clk) begin
        if (mem_we) begin
            we_cnt++;
            we_cyc = cyc;
        end
        if (mem_addr != 32'd0) acc_cnt++;
        if (clrn && !mem_we) chk("datain_outside_write", mem_datain, 32'd0);
    end

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          stall;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];

    // Monitor: pops on the first cycle of each response, then checks it every cycle it is held
    exp_t cur;
    int   cur_acc = 0;
    int   stall_left = 0;
    bit   in_resp = 1'b0;
    always @(negedge clk) begin
        if (!clrn) begin
            in_resp   = 1'b0;
            rsp_ready = 1'b0;
        end else if (rsp_valid) begin
            if (!in_resp) begin
                in_resp = 1'b1;
                if (exp_q.size() == 0) begin
                    chk("unexpected_response", 32'd1, 32'd0);
                    cur.name = "none"; cur.rdata = 32'd0; cur.err = 1'b0;
                    cur.lat = 0; cur.stall = 0;
                    cur_acc = cyc;
                end else begin
                    cur = exp_q.pop_front();
                    cur_acc = acc_q.pop_front();
                end
                chk({cur.name, " latency"}, 32'(cyc - cur_acc), 32'(cur.lat));
                stall_left = cur.stall;
                $display("rsp %s rdata=%h err=%b lat=%0d", cur.name, rsp_rdata, rsp_err, cyc - cur_acc);
            end else if (stall_left > 0) begin
                stall_left--;
            end
            chk({cur.name, " rdata"}, rsp_rdata, cur.rdata);
            chk({cur.name, " err"}, {31'd0, rsp_err}, {31'd0, cur.err});
            chk({cur.name, " req_ready_busy"}, {31'd0, req_ready}, 32'd0);
            rsp_ready = (stall_left == 0);
        end else begin
            in_resp   = 1'b0;
            rsp_ready = 1'b0;
        end
    end

    task automatic issue(input string nm, input logic we, input logic [1:0] size, input logic sext,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err, input int lat,
                         input int stall, input int exp_acc, input int exp_we, input int we_off,
                         input int midx, input logic [31:0] mexp);
        int   we0 = we_cnt;
        int   acc0 = acc_cnt;
        int   t = 0;
        int   a;
        exp_t e;
        @(negedge clk);
        req_we = we; req_size = size; req_sext = sext; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        while (!req_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk({nm, " accept_timeout"}, {31'd0, req_ready}, 32'd1);
        a = cyc;
        e.name = nm; e.rdata = exp_rdata; e.err = exp_err; e.lat = lat; e.stall = stall;
        acc_q.push_back(a);
        exp_q.push_back(e);
        @(posedge clk);
        #1 req_valid = 1'b0;
        t = 0;
        while ((exp_q.size() != 0 || rsp_valid) && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk({nm, " done_timeout"}, {31'd0, t < 50}, 32'd1);
        chk({nm, " mem_access_cycles"}, 32'(acc_cnt - acc0), 32'(exp_acc));
        chk({nm, " we_pulses"}, 32'(we_cnt - we0), 32'(exp_we));
        if (exp_we > 0) chk({nm, " we_offset"}, 32'(we_cyc - a), 32'(we_off));
        chk({nm, " mem_word"}, mem[midx], mexp);
        $display("txn %s we=%b size=%b addr=%h wdata=%h mem[%0d]=%h", nm, we, size, addr, wdata, midx, mem[midx]);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst rsp_rdata", rsp_rdata, 32'd0);
        chk("rst mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst mem_addr", mem_addr, 32'd0);
        chk("rst mem_datain", mem_datain, 32'd0);
        clrn = 1'b1;

        //     name             we  size  sx addr        wdata         rdata          err lat st acc we off idx mem
        issue("lb_sext",       0, 2'b00, 1, 32'h50, 32'h0,        32'hFFFF_FFA3, 0, 2, 0, 1, 0, 0, 20, 32'h0000_00a3);
        issue("lbu",           0, 2'b00, 0, 32'h50, 32'h0,        32'h0000_00A3, 0, 2, 0, 1, 0, 0, 20, 32'h0000_00a3);
        issue("sh_56",         1, 2'b01, 0, 32'h56, 32'h0000_BEEF, 32'h0,        0, 3, 0, 2, 1, 2, 21, 32'hBEEF_0027);
        issue("sw_60",         1, 2'b10, 0, 32'h60, 32'h0000_0258, 32'h0,        0, 2, 0, 1, 1, 1, 24, 32'h0000_0258);
`ifdef LSU_MISALIGN_CHECK_EN
        issue("lw_51_misal",   0, 2'b10, 0, 32'h51, 32'h0,        32'h0,         1, 1, 0, 0, 0, 0, 20, 32'h0000_00a3);
`else
        issue("lw_51",         0, 2'b10, 0, 32'h51, 32'h0,        32'h0000_00a3, 0, 2, 0, 1, 0, 0, 20, 32'h0000_00a3);
`endif
        issue("lw_oob_80",     0, 2'b10, 0, 32'h80, 32'h0,        32'h0,         1, 1, 0, 0, 0, 0, 20, 32'h0000_00a3);
        issue("size_11",       0, 2'b11, 0, 32'h50, 32'h0,        32'h0,         1, 1, 0, 0, 0, 0, 20, 32'h0000_00a3);
        issue("sw_oob_err",    1, 2'b10, 0, 32'h84, 32'h1234,     32'h0,         1, 1, 0, 0, 0, 0, 24, 32'h0000_0258);
        issue("lh_56_sext",    0, 2'b01, 1, 32'h56, 32'h0,        32'hFFFF_BEEF, 0, 2, 0, 1, 0, 0, 21, 32'hBEEF_0027);
        issue("lhu_56",        0, 2'b01, 0, 32'h56, 32'h0,        32'h0000_BEEF, 0, 2, 0, 1, 0, 0, 21, 32'hBEEF_0027);
        issue("lb_57_sext",    0, 2'b00, 1, 32'h57, 32'h0,        32'hFFFF_FFBE, 0, 2, 0, 1, 0, 0, 21, 32'hBEEF_0027);
        issue("sb_54",         1, 2'b00, 0, 32'h54, 32'hCAFE_0011, 32'h0,        0, 3, 0, 2, 1, 2, 21, 32'hBEEF_0011);
`ifdef LSU_MISALIGN_CHECK_EN
        issue("lh_55_misal",   0, 2'b01, 0, 32'h55, 32'h0,        32'h0,         1, 1, 0, 0, 0, 0, 21, 32'hBEEF_0011);
`else
        issue("lh_55",         0, 2'b01, 0, 32'h55, 32'h0,        32'h0000_0011, 0, 2, 0, 1, 0, 0, 21, 32'hBEEF_0011);
`endif
        issue("lw_60_stall",   0, 2'b10, 0, 32'h60, 32'h0,        32'h0000_0258, 0, 2, 5, 1, 0, 0, 24, 32'h0000_0258);

        // Reset asserted while a byte store sits in WRITE
        @(negedge clk);
        req_we = 1'b1; req_size = 2'b00; req_sext = 1'b0; req_addr = 32'h58; req_wdata = 32'h0000_00AA;
        req_valid = 1'b1;
        chk("rmw_rst accept_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rmw_rst write_pending", {31'd0, mem_we}, 32'd1);
        clrn = 1'b0;
        #1;
        chk("rmw_rst we_gated", {31'd0, mem_we}, 32'd0);
        @(negedge clk);
        chk("rmw_rst word_unchanged", mem[22], 32'h1122_3344);
        chk("rmw_rst req_ready", {31'd0, req_ready}, 32'd1);
        chk("rmw_rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rmw_rst mem_addr", mem_addr, 32'd0);
        $display("txn rmw_rst sb addr=00000058 mem[22]=%h", mem[22]);
        clrn = 1'b1;

        issue("lbu_58_postrst", 0, 2'b00, 0, 32'h58, 32'h0,       32'h0000_0044, 0, 2, 0, 1, 0, 0, 22, 32'h1122_3344);
        issue("lbu_5b",         0, 2'b00, 0, 32'h5B, 32'h0,       32'h0000_0011, 0, 2, 0, 1, 0, 0, 22, 32'h1122_3344);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sc_mem_lsu.md
SC_MEM_LSU -- requirements
Module: sc_mem_lsu

Interface
REQ-001 SHALL have parameter: MEM_WORDS, 32, number of 32-bit words in the attached data memory.
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on posedge.
REQ-003 SHALL have port: clrn  in  1  reset, synchronous and active-low.
REQ-004 SHALL have ports: req_valid in 1; req_ready out 1; req_we in 1 (1=store); req_size in 2 (00 byte, 01 half, 10 word, 11 reserved); req_sext in 1 (sign-extend loads); req_addr in 32; req_wdata in 32.
REQ-005 SHALL have ports: rsp_valid out 1; rsp_ready in 1; rsp_rdata out 32; rsp_err out 1.
REQ-006 SHALL have memory-side ports: mem_addr out 32; mem_datain out 32; mem_we out 1; mem_dataout in 32 (combinational read, write on posedge).

Function
REQ-007 SHALL implement FSM states IDLE, LOAD, READ, WRITE, RESP.
REQ-008 SHALL assert req_ready only in IDLE; accept on req_valid&req_ready and latch we/size/sext/addr/wdata.
REQ-009 On accept SHALL go to RESP with err=1 if size=11 or addr[31:2] >= MEM_WORDS; no memory access.
REQ-010 Otherwise on accept: load -> LOAD; word store -> WRITE; byte/half store -> READ.
REQ-011 LOAD SHALL capture the lane-extracted value of mem_dataout into rsp_rdata, then go to RESP.
REQ-012 READ SHALL capture mem_dataout, merge store data into the selected lane(s), then go to WRITE.
REQ-013 WRITE SHALL drive mem_we=1 for exactly one cycle with the merged word (or the full wdata for word stores), then go to RESP.
REQ-014 RESP SHALL hold rsp_valid=1 with stable rdata/err until rsp_ready=1, then return to IDLE; rsp_rdata=0 for stores and errors.
REQ-015 Lanes SHALL be little-endian: byte lane=addr[1:0], half lane=addr[1]; loads zero-extend unless req_sext=1.
REQ-016 mem_addr SHALL be {addr[31:2],2'b00} in LOAD/READ/WRITE, else 0; mem_datain SHALL be 0 outside WRITE; mem_we SHALL be 0 outside WRITE.
REQ-017 Latency accept->rsp_valid SHALL be: error 1, load 2, word store 2, sub-word store 3 cycles.
REQ-018 A new request SHALL NOT be accepted in the same cycle as a response handshake; the earliest accept is the cycle after.

Reset
REQ-019 When clrn=0 at a posedge, SHALL go to IDLE and clear all latched fields, rsp_rdata and rsp_err.
REQ-020 mem_we SHALL be gated by clrn so no memory write occurs on an edge where clrn=0, including when reset hits WRITE mid-RMW.
REQ-021 After reset, outputs SHALL be: req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_we=0, mem_addr=0, mem_datain=0.

Configuration
REQ-022 Macro LSU_MISALIGN_CHECK_EN defined: a half access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL be an error (REQ-009 path, no memory access).
REQ-023 Macro LSU_MISALIGN_CHECK_EN undefined: the unit SHALL ignore addr[0] for half accesses and addr[1:0] for word accesses; no misalignment error.

Verification
REQ-024 Word 0x14 = 0x000000a3; byte load addr 0x50, sext=1 -> rsp_rdata=0xFFFFFFA3 at accept+2; with sext=0 -> 0x000000A3.
REQ-025 Word 0x15 = 0x00000027; half store 0x0000BEEF to addr 0x56 -> one READ, one mem_we pulse at accept+2, word 0x15 = 0xBEEF0027, rsp_valid at accept+3.
REQ-026 Word store 0x00000258 to addr 0x60 -> mem_we at accept+1 only, word 0x18 = 0x00000258, rsp_err=0.
REQ-027 Word load addr 0x51: with macro -> rsp_err=1 at accept+1, no mem access; without -> rsp_rdata = word 0x14.
REQ-028 Load addr 0x80 (MEM_WORDS=32) -> rsp_err=1, rsp_rdata=0; size=11 -> rsp_err=1.
REQ-029 clrn=0 during WRITE of a byte store -> target word unchanged, FSM in IDLE, req_ready=1 next cycle; rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rdata stay stable.
